uart_rx_fc: RTL and testbench
=============================

# uart_rx_fc

Byte-oriented UART receiver with hardware flow control. It samples the asynchronous `rxd` pin, which is driven by the USB-UART adapter on the GPIO header, and deframes 8N1 characters. Received bytes are buffered in a small first-word-fall-through (FWFT) FIFO. It drives `rts` to throttle the remote sender when the FIFO nears full. It is the receiving end of the serial link whose transmit side drives `txd`/`cts`, and sits between the board pins and the on-chip peripheral bus.

## Interface
- `BAUD_DIV`, default 87: clocks per bit time (10 MHz / 115200). Must be ≥ 4.
- `FIFO_DEPTH`, default 4: receive FIFO entries. Must be a power of 2, ≥ 2.
- `RTS_THRESHOLD`, default 1: `rts` deasserts when free entries ≤ this value.
- `clk` in 1: the single clock.
- `n_rst` in 1: reset, asynchronous, active-low.
- `rxd` in 1: serial input from the pin. Asynchronous; idle high.
- `rts` out 1: flow control, pin-level active-low. 0 = remote may send; 1 = hold off.
- `data` out 8: FIFO head byte. Valid only while `valid`=1.
- `valid` out 1: FIFO non-empty.
- `ready` in 1: consumer pops the head on a cycle where `valid`&&`ready`.
- `framing_error` out 1: one-cycle pulse when a stop bit samples 0.
- `overrun_error` out 1: one-cycle pulse when a good byte is dropped because the FIFO is full.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: current occupancy.

## Operation
- **Input synchronizer.** `rxd` passes through a 2-flop synchronizer preset to 1 (`rxs`). A falling-edge detector is registered on `rxs`.
- **Bit-timer.** A counter sized for `BAUD_DIV`-1. It reloads on every state entry and expires at 0.
- **FSM states:** IDLE, START, DATA, STOP.
- **IDLE.** On a 1→0 edge of `rxs`, load the timer with `BAUD_DIV/2`-1 and go to START.
- **START.** On expiry:
  - `rxs`=0: load `BAUD_DIV`-1, clear the bit index, go to DATA.
  - `rxs`=1: false start; return to IDLE with no output.
- **DATA.** On each expiry, shift `rxs` into the shift register LSB-first and reload `BAUD_DIV`-1. After bit index 7, go to STOP.
- **STOP.** On expiry:
  - `rxs`=1: push the byte.
  - `rxs`=0: pulse `framing_error` and discard the byte.
  - In both cases go to IDLE. Re-arming requires a new 1→0 edge, so a line held low (break) produces exactly one `framing_error` and no further frames.
- **FIFO.** Circular buffer with read/write pointers of width $clog2(FIFO_DEPTH), which wrap naturally.
  - `fifo_count` = writes − reads.
  - A push is accepted when `fifo_count`<`FIFO_DEPTH`, or when a pop occurs in the same cycle. Full + simultaneous pop + push leaves the count at `FIFO_DEPTH` with the byte stored.
  - A push with the FIFO full and no pop: the byte is dropped, `overrun_error` pulses, and FIFO contents are unchanged.
  - A pop while empty is ignored.
- **`rts`.** Registered: `rts` <= (`FIFO_DEPTH` − next `fifo_count`) ≤ `RTS_THRESHOLD`.
- **Error pulses.** `framing_error` and `overrun_error` are mutually exclusive within a frame.

## Timing
- **Reset values:**
  - FSM IDLE; synchronizer flops 1.
  - `rts`=1, `valid`=0, `data`=0, `fifo_count`=0, `framing_error`=0, `overrun_error`=0.
  - `rts` falls to 0 on the first clock edge after `n_rst` releases.
- **Reset mid-frame.** The FSM, FIFO and pointers clear immediately. The partial frame is lost. Reception resumes on the next falling edge after release.
- **Latency, pin edge to sample.** 2 cycles for synchronization plus 1 cycle for edge detection. The start bit is sampled `BAUD_DIV/2` cycles after detection. Data bit n is sampled `BAUD_DIV`·(n+1) cycles after the start sample.
- **Latency, stop sample to output.** The push is registered at the stop-sample edge. `valid`, `data` and `fifo_count` update at that same edge and are visible the following cycle. `rts` updates on the same edge as `fifo_count`.
- **FWFT behaviour.** `data` always reflects the head entry. After a pop, the next entry appears the following cycle with no bubble.
- **Back-to-back frames.** Supported: IDLE is entered at the stop-bit centre, so the next start edge half a bit later is captured.
- **Baud tolerance.** ±2% cumulative over 10 bits.

## Test plan
- **Single byte.** `BAUD_DIV`=8: send 0x55 with `ready`=1 → `valid` pulses one cycle with `data`=0x55; no error pulses; `rts` stays 0.
- **FIFO fill and flow control.** `FIFO_DEPTH`=4, `RTS_THRESHOLD`=1, `ready`=0: send 0x01..0x05 back-to-back →
  - `rts`=1 after the 3rd byte;
  - `fifo_count`=4 after the 4th;
  - 5th byte dropped with one `overrun_error` pulse;
  - then raise `ready` → reads 0x01,0x02,0x03,0x04 on consecutive cycles, and `rts` returns to 0.
- **Framing error.** Send 0xA3 with the stop bit forced low → `framing_error` one cycle, `fifo_count` unchanged. Release the line and send 0x3C → received correctly.
- **Glitch rejection.** A 2-cycle low pulse on `rxd` with `BAUD_DIV`=8 → no output, no error, FSM back in IDLE within 5 cycles.
- **Reset mid-frame.** Assert `n_rst` low during data bit 4 of 0xFF with 2 bytes already queued →
  - `valid`=0, `fifo_count`=0, `rts`=1 during reset;
  - after release, `rts`=0 within 1 cycle;
  - the next byte 0x7E is received correctly.
- **Full with simultaneous pop and push.** FIFO full; a stop bit completes on the same cycle as a pop → byte stored, `fifo_count` stays 4, no `overrun_error`.

Source files
------------

// File: rtl/uart_rx_fc.sv
// uart_rx_fc: 8N1 UART receiver with a first-word-fall-through receive FIFO
// and an active-low RTS output that holds off the sender when the FIFO is
// nearly full.
module uart_rx_fc #(
    parameter int BAUD_DIV      = 87,
    parameter int FIFO_DEPTH    = 4,
    parameter int RTS_THRESHOLD = 1
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          rxd,
    output logic                          rts,
    output logic [7:0]                    data,
    output logic                          valid,
    input  logic                          ready,
    output logic                          framing_error,
    output logic                          overrun_error,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int DATA_W = 8;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = AW + 1;
    localparam int TW     = $clog2(BAUD_DIV);

    localparam logic [TW-1:0] RELOAD_FULL = TW'(BAUD_DIV - 1);
    localparam logic [TW-1:0] RELOAD_HALF = TW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] RTS_THR_C   = CW'(RTS_THRESHOLD);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t              state_q, state_n;
    logic                rx_p0, rxs, rxs_p1;
    logic                fall;
    logic [TW-1:0]       timer_q, timer_n;
    logic                expired;
    logic [2:0]          bit_q, bit_n;
    logic [DATA_W-1:0]   shift_q, shift_n;
    logic                push, ferr_n;

    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       count_q, count_n;
    logic                pop, push_ok;

    assign fall    = rxs_p1 & ~rxs;
    assign expired = (timer_q == '0);

    // Two-flop synchronizer on the asynchronous pin plus one delay flop for edge detection
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_p0  <= 1'b1;
            rxs    <= 1'b1;
            rxs_p1 <= 1'b1;
        end else begin
            rx_p0  <= rxd;
            rxs    <= rx_p0;
            rxs_p1 <= rxs;
        end
    end

    // Receiver state, bit timer and bit index registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_n;
            timer_q <= timer_n;
            bit_q   <= bit_n;
        end
    end

    // Shift register holds only data, so it needs no reset
    always_ff @(posedge clk) begin
        shift_q <= shift_n;
    end

    // Frame sequencing: half-bit to the start centre, then full bits to each data/stop centre
    always_comb begin
        state_n = state_q;
        timer_n = expired ? timer_q : timer_q - TW'(1);
        bit_n   = bit_q;
        shift_n = shift_q;
        push    = 1'b0;
        ferr_n  = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall) begin
                    timer_n = RELOAD_HALF;
                    state_n = START;
                end
            end
            START: begin
                if (expired) begin
                    if (!rxs) begin
                        timer_n = RELOAD_FULL;
                        bit_n   = '0;
                        state_n = DATA;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DATA: begin
                if (expired) begin
                    shift_n = {rxs, shift_q[DATA_W-1:1]};
                    timer_n = RELOAD_FULL;
                    bit_n   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_n = STOP;
                    end
                end
            end
            STOP: begin
                if (expired) begin
                    if (rxs) begin
                        push = 1'b1;
                    end else begin
                        ferr_n = 1'b1;
                    end
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // A pop in the same cycle frees the slot, so a full FIFO can still take the byte
    assign valid   = (count_q != '0);
    assign pop     = valid & ready;
    assign push_ok = push & ((count_q < DEPTH_C) | pop);
    assign data    = valid ? mem[rd_ptr] : '0;

    // Occupancy after this cycle's push/pop, used for both count and rts
    always_comb begin
        count_n = count_q;
        case ({push_ok, pop})
            2'b10:   count_n = count_q + CW'(1);
            2'b01:   count_n = count_q - CW'(1);
            default: count_n = count_q;
        endcase
    end

    // FIFO storage write; contents are data only and are not reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= shift_q;
        end
    end

    // FIFO pointers, occupancy, flow control and error pulses
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count_q       <= '0;
            rts           <= 1'b1;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_q       <= count_n;
            rts           <= ((DEPTH_C - count_n) <= RTS_THR_C);
            framing_error <= ferr_n;
            overrun_error <= push & ~push_ok;
        end
    end

    assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_rx_fc.sv
// tb_uart_rx_fc: directed/randomized bench for uart_rx_fc with a queue-based
// reference model of the receive FIFO and flow control.
module tb_uart_rx_fc;

    localparam int BD    = 8;
    localparam int DEPTH = 4;
    localparam int THR   = 1;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       rxd = 1'b1;
    logic       ready = 1'b0;
    logic       rts;
    logic [7:0] data;
    logic       valid;
    logic       framing_error;
    logic       overrun_error;
    logic [2:0] fifo_count;

    always #5 clk = ~clk;

    uart_rx_fc #(.BAUD_DIV(BD), .FIFO_DEPTH(DEPTH), .RTS_THRESHOLD(THR)) dut (
        .clk(clk), .n_rst(n_rst), .rxd(rxd), .rts(rts), .data(data),
        .valid(valid), .ready(ready), .framing_error(framing_error),
        .overrun_error(overrun_error), .fifo_count(fifo_count)
    );

    int checks = 0;
    int failures = 0;

    // monitor: collected on the falling edge, away from the active edge
    logic [7:0] popped[$];
    int         pop_stamp[$];
    int         cyc = 0;
    int         fe_cnt = 0;
    int         oe_cnt = 0;
    int         vld_cnt = 0;
    int         rts_hi = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (n_rst) begin
            if (valid && ready) begin
                popped.push_back(data);
                pop_stamp.push_back(cyc);
            end
            if (framing_error) fe_cnt <= fe_cnt + 1;
            if (overrun_error) oe_cnt <= oe_cnt + 1;
            if (valid)         vld_cnt <= vld_cnt + 1;
            if (rts)           rts_hi <= rts_hi + 1;
        end
    end

    // reference model: FIFO contents as a queue, expected output stream
    logic [7:0] model_q[$];
    logic [7:0] exp_pop[$];
    int         exp_ovr = 0;
    int         exp_fe = 0;
    int         pchk = 0;

    function automatic void model_frame(input logic [7:0] b, input logic stop, input logic pop_same);
        if (!stop) begin
            exp_fe++;
            return;
        end
        if (pop_same && model_q.size() > 0) exp_pop.push_back(model_q.pop_front());
        if (model_q.size() < DEPTH) model_q.push_back(b);
        else exp_ovr++;
    endfunction

    function automatic void model_drain();
        while (model_q.size() > 0) exp_pop.push_back(model_q.pop_front());
    endfunction

    function automatic logic [31:0] model_rts();
        return ((DEPTH - model_q.size()) <= THR) ? 32'd1 : 32'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_pops(input string tag);
        int n;
        check({tag, "_count"}, popped.size(), exp_pop.size());
        n = (popped.size() < exp_pop.size()) ? popped.size() : exp_pop.size();
        for (int i = pchk; i < n; i++) check({tag, "_byte"}, popped[i], exp_pop[i]);
        if (n > pchk) pchk = n;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // one 8N1 frame, one bit per BD cycles; optional one-cycle ready pulse and early abort
    task automatic send(input logic [7:0] b, input logic stop_bit, input int pop_cyc, input int abort_cyc);
        int k;
        for (int i = 0; i < 10 * BD; i++) begin
            if (i == abort_cyc) return;
            k = i / BD;
            if (k == 0)      rxd = 1'b0;
            else if (k == 9) rxd = stop_bit;
            else             rxd = b[k-1];
            if (pop_cyc >= 0) ready = (i == pop_cyc);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [7:0] b;
        int base_v, base_r, base_fe, base_pop, g;

        // reset values
        n_rst = 1'b0; rxd = 1'b1; ready = 1'b0;
        idle(3);
        check("rst_rts", rts, 1);
        check("rst_valid", valid, 0);
        check("rst_data", data, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ferr", framing_error, 0);
        check("rst_oerr", overrun_error, 0);
        n_rst = 1'b1;
        idle(1);
        check("rts_after_release", rts, 0);
        idle(4);

        // single bytes with ready held high
        ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            b = (n == 0) ? 8'h55 : 8'($urandom_range(0, 255));
            base_v = vld_cnt; base_r = rts_hi;
            send(b, 1'b1, -1, -1);
            model_frame(b, 1'b1, 1'b0);
            model_drain();
            idle(2);
            check("single_valid_cycles", vld_cnt - base_v, 1);
            check("single_rts_low", rts_hi - base_r, 0);
        end
        compare_pops("single");
        check("single_ferr", fe_cnt, exp_fe);
        check("single_oerr", oe_cnt, exp_ovr);

        // fill with ready low, back-to-back, fifth byte overruns
        ready = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            b = 8'(n);
            send(b, 1'b1, -1, -1);
            model_frame(b, 1'b1, 1'b0);
            check("fill_rts", rts, model_rts());
            check("fill_count", fifo_count, model_q.size());
            check("fill_oerr", oe_cnt, exp_ovr);
        end
        base_pop = pop_stamp.size();
        ready = 1'b1;
        idle(6);
        ready = 1'b0;
        model_drain();
        compare_pops("drain");
        if (pop_stamp.size() >= base_pop + 4)
            check("drain_back_to_back", pop_stamp[base_pop+3] - pop_stamp[base_pop], 3);
        else
            check("drain_pops_seen", pop_stamp.size() - base_pop, 4);
        check("drain_rts", rts, 0);
        check("drain_count", fifo_count, 0);

        // framing error, then line held low (break) for many bit times
        ready = 1'b1;
        send(8'hA3, 1'b0, -1, -1);
        model_frame(8'hA3, 1'b0, 1'b0);
        idle(150);
        check("ferr_once", fe_cnt, exp_fe);
        check("ferr_count", fifo_count, 0);
        check("ferr_no_oerr", oe_cnt, exp_ovr);
        rxd = 1'b1;
        idle(10);
        send(8'h3C, 1'b1, -1, -1);
        model_frame(8'h3C, 1'b1, 1'b0);
        model_drain();
        idle(2);
        compare_pops("after_ferr");

        // glitch rejection, followed closely by a real frame
        base_fe = fe_cnt; base_v = popped.size();
        g = $urandom_range(1, 2);
        rxd = 1'b0;
        idle(g);
        rxd = 1'b1;
        idle(5);
        check("glitch_no_ferr", fe_cnt - base_fe, 0);
        check("glitch_no_data", popped.size() - base_v, 0);
        b = 8'($urandom_range(0, 255));
        send(b, 1'b1, -1, -1);
        model_frame(b, 1'b1, 1'b0);
        model_drain();
        idle(2);
        compare_pops("after_glitch");

        // reset during data bit 4 of 0xFF with two bytes queued
        ready = 1'b0;
        for (int n = 0; n < 2; n++) begin
            b = 8'($urandom_range(0, 255));
            send(b, 1'b1, -1, -1);
            model_frame(b, 1'b1, 1'b0);
        end
        check("preq_count", fifo_count, model_q.size());
        send(8'hFF, 1'b1, -1, 5 * BD + BD / 2);
        n_rst = 1'b0;
        #2;
        model_q.delete();
        check("midrst_valid", valid, 0);
        check("midrst_count", fifo_count, 0);
        check("midrst_rts", rts, 1);
        check("midrst_data", data, 0);
        rxd = 1'b1;
        idle(2);
        n_rst = 1'b1;
        idle(1);
        check("midrst_rts_release", rts, 0);
        idle(3);
        ready = 1'b1;
        send(8'h7E, 1'b1, -1, -1);
        model_frame(8'h7E, 1'b1, 1'b0);
        model_drain();
        idle(2);
        compare_pops("after_midrst");

        // full FIFO with a pop on the same edge as the stop sample
        ready = 1'b0;
        for (int n = 0; n < 4; n++) begin
            b = 8'($urandom_range(0, 255));
            send(b, 1'b1, -1, -1);
            model_frame(b, 1'b1, 1'b0);
        end
        check("full_count", fifo_count, 4);
        b = 8'($urandom_range(0, 255));
        send(b, 1'b1, 10 * BD - 2, -1);
        model_frame(b, 1'b1, 1'b1);
        check("simul_count", fifo_count, model_q.size());
        check("simul_oerr", oe_cnt, exp_ovr);
        check("simul_rts", rts, model_rts());
        ready = 1'b1;
        idle(6);
        ready = 1'b0;
        model_drain();
        compare_pops("simul_drain");
        check("final_ferr", fe_cnt, exp_fe);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
